// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and pin-idle levels
// for the Wishbone-to-async-SRAM bridge.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
  } sram_state_t;

  localparam logic SRAM_IDLE_CE_N = 1'b1;
  localparam logic SRAM_IDLE_OE_N = 1'b1;
  localparam logic SRAM_IDLE_WE_N = 1'b1;

endpackage

// File: rtl/sram_controller.sv
// sram_controller: Wishbone B4 classic slave driving an
// async SRAM with a fixed-timing FSM and registered pins.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 20,
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int WAIT_CYCLES     = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  input  logic                         wb_we_i,
  input  logic [ADDR_WIDTH-1:0]        wb_adr_i,
  input  logic [DATA_WIDTH-1:0]        wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0]      wb_sel_i,
  output logic                         wb_ack_o,
  output logic [DATA_WIDTH-1:0]        wb_dat_o,
  output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr,
  input  logic [SRAM_DATA_WIDTH-1:0]   sram_data_i,
  output logic [SRAM_DATA_WIDTH-1:0]   sram_data_o,
  output logic                         sram_data_oe,
  output logic                         sram_ce_n,
  output logic                         sram_oe_n,
  output logic                         sram_we_n,
  output logic [SRAM_DATA_WIDTH/8-1:0] sram_be_n
);

  localparam int BW = SRAM_DATA_WIDTH / 8;
  localparam int CW =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] W_LAST = CW'(WAIT_CYCLES);

  sram_state_t                r_state, w_state;
  logic [CW-1:0]              r_cnt, w_cnt;
  logic [SRAM_ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [SRAM_DATA_WIDTH-1:0] r_dout, w_dout;
  logic [DATA_WIDTH-1:0]      r_rdata, w_rdata;
  logic [BW-1:0]              r_be_n, w_be_n;
  logic                       r_doe, w_doe;
  logic                       r_ce_n, w_ce_n;
  logic                       r_oe_n, w_oe_n;
  logic                       r_we_n, w_we_n;

  logic w_req;
  logic w_last;
  logic w_unused;

  assign w_req  = wb_cyc_i & wb_stb_i;
  assign w_last = (r_cnt == W_LAST);

  // Word addressing: byte offset and upper bits drop out.
  assign w_unused = ^{wb_adr_i[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2],
                      wb_adr_i[1:0]};

  // Next-state and next-pin values; every register holds by default.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_addr  = r_addr;
    w_dout  = r_dout;
    w_rdata = r_rdata;
    w_be_n  = r_be_n;
    w_doe   = r_doe;
    w_ce_n  = r_ce_n;
    w_oe_n  = r_oe_n;
    w_we_n  = r_we_n;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_addr = wb_adr_i[SRAM_ADDR_WIDTH+1:2];
          w_be_n = ~wb_sel_i;
          w_dout = wb_dat_i;
          w_ce_n = 1'b0;
          w_cnt  = '0;
          unique case (1'b1)
            wb_we_i: begin
              w_state = S_WR_SETUP;
              w_doe   = 1'b1;
              w_we_n  = SRAM_IDLE_WE_N;
            end
            default: begin
              w_state = S_READ;
              w_oe_n  = 1'b0;
            end
          endcase
        end
      end
      S_READ: begin
        if (w_last) begin
          w_rdata = sram_data_i;
          w_oe_n  = SRAM_IDLE_OE_N;
          w_ce_n  = SRAM_IDLE_CE_N;
          w_be_n  = '1;
          w_state = S_DONE;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_WR_SETUP: begin
        w_we_n  = 1'b0;
        w_cnt   = '0;
        w_state = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (w_last) begin
          w_we_n  = SRAM_IDLE_WE_N;
          w_state = S_WR_HOLD;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_WR_HOLD: begin
        w_doe   = 1'b0;
        w_ce_n  = SRAM_IDLE_CE_N;
        w_be_n  = '1;
        w_state = S_DONE;
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  // State and SRAM pin registers; reset parks the pins idle at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_dout  <= '0;
      r_rdata <= '0;
      r_be_n  <= '1;
      r_doe   <= 1'b0;
      r_ce_n  <= SRAM_IDLE_CE_N;
      r_oe_n  <= SRAM_IDLE_OE_N;
      r_we_n  <= SRAM_IDLE_WE_N;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_addr  <= w_addr;
      r_dout  <= w_dout;
      r_rdata <= w_rdata;
      r_be_n  <= w_be_n;
      r_doe   <= w_doe;
      r_ce_n  <= w_ce_n;
      r_oe_n  <= w_oe_n;
      r_we_n  <= w_we_n;
    end
  end

  // Ack only while the master still owns the cycle.
  assign wb_ack_o     = (r_state == S_DONE) & wb_cyc_i;
  assign wb_dat_o     = r_rdata;
  assign sram_addr    = r_addr;
  assign sram_data_o  = r_dout;
  assign sram_data_oe = r_doe;
  assign sram_ce_n    = r_ce_n;
  assign sram_oe_n    = r_oe_n;
  assign sram_we_n    = r_we_n;
  assign sram_be_n    = r_be_n;

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: two controller instances (0 and 2 wait
// cycles) against SRAM device models and a word-level reference.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        cyc, stb, we, dsel;
  logic [31:0] adr, dat;
  logic [3:0]  sel;

  logic        cyc0, stb0, cyc2, stb2;
  logic        ack0, ack2, doe0, doe2;
  logic        ce0, ce2, oe0, oe2, we0, we2;
  logic [31:0] rd0, rd2, do0, do2, di0, di2;
  logic [19:0] a0, a2;
  logic [3:0]  be0, be2;

  logic        m_ack, m_doe, m_ce_n, m_oe_n, m_we_n;
  logic [31:0] m_rdat;
  logic [19:0] m_addr;
  logic [3:0]  m_be_n;

  bit [31:0] dev0 [0:1048575];
  bit [31:0] dev2 [0:1048575];
  bit [31:0] ref0 [int];
  bit [31:0] ref2 [int];

  logic        pl_go;
  logic [19:0] pl_a;
  logic [31:0] pl_d;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int lat, wl, ol, ack_t, n;
  logic [19:0] sa;
  logic [3:0]  sb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  assign cyc0 = cyc & ~dsel;
  assign stb0 = stb & ~dsel;
  assign cyc2 = cyc & dsel;
  assign stb2 = stb & dsel;

  sram_controller #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .wb_cyc_i(cyc0), .wb_stb_i(stb0), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
    .wb_ack_o(ack0), .wb_dat_o(rd0),
    .sram_addr(a0), .sram_data_i(di0), .sram_data_o(do0),
    .sram_data_oe(doe0), .sram_ce_n(ce0), .sram_oe_n(oe0),
    .sram_we_n(we0), .sram_be_n(be0)
  );

  sram_controller #(.WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .wb_cyc_i(cyc2), .wb_stb_i(stb2), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
    .wb_ack_o(ack2), .wb_dat_o(rd2),
    .sram_addr(a2), .sram_data_i(di2), .sram_data_o(do2),
    .sram_data_oe(doe2), .sram_ce_n(ce2), .sram_oe_n(oe2),
    .sram_we_n(we2), .sram_be_n(be2)
  );

  // Async SRAM devices: read path live while ce/oe low.
  always_comb di0 = (!ce0 && !oe0) ? dev0[a0] : 32'hA5A5_5A5A;
  always_comb di2 = (!ce2 && !oe2) ? dev2[a2] : 32'hA5A5_5A5A;

  always @(posedge clk) begin
    if (pl_go) dev0[pl_a] <= pl_d;
    if (!ce0 && !we0 && doe0)
      for (int b = 0; b < 4; b++)
        if (!be0[b]) dev0[a0][8*b +: 8] <= do0[8*b +: 8];
  end

  always @(posedge clk) begin
    if (!ce2 && !we2 && doe2)
      for (int b = 0; b < 4; b++)
        if (!be2[b]) dev2[a2][8*b +: 8] <= do2[8*b +: 8];
  end

  always_comb begin
    m_ack  = dsel ? ack2 : ack0;
    m_doe  = dsel ? doe2 : doe0;
    m_ce_n = dsel ? ce2  : ce0;
    m_oe_n = dsel ? oe2  : oe0;
    m_we_n = dsel ? we2  : we0;
    m_rdat = dsel ? rd2  : rd0;
    m_addr = dsel ? a2   : a0;
    m_be_n = dsel ? be2  : be0;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Pad contention and write-pulse window, every cycle, both units.
  always @(negedge clk) begin
    chk("bus0", {30'b0, doe0 & ~oe0, ~we0 & ~doe0}, 32'd0);
    chk("bus2", {30'b0, doe2 & ~oe2, ~we2 & ~doe2}, 32'd0);
  end

  function automatic bit [31:0] ref_rd(input int i);
    if (dsel) return ref2.exists(i) ? ref2[i] : 32'd0;
    return ref0.exists(i) ? ref0[i] : 32'd0;
  endfunction

  task automatic ref_wr(input int i, input logic [31:0] d,
                        input logic [3:0] s);
    bit [31:0] w;
    w = ref_rd(i);
    for (int b = 0; b < 4; b++)
      if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    if (dsel) ref2[i] = w;
    else ref0[i] = w;
  endtask

  task automatic preload(input logic [19:0] a, input logic [31:0] d);
    pl_a = a; pl_d = d; pl_go = 1'b1;
    @(posedge clk);
    #1 pl_go = 1'b0;
    ref0[int'(a)] = d;
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, d,
                      input logic [3:0] s, input logic keep);
    int k;
    bit got, seen;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = a; dat = d; sel = s;
    k = 0; got = 0; seen = 0; wl = 0; ol = 0;
    sa = 'x; sb = 'x;
    while (!got && k < 40) begin
      @(negedge clk);
      if (!m_we_n) wl++;
      if (!m_oe_n) ol++;
      if (!seen && !m_ce_n) begin
        sa = m_addr; sb = m_be_n; seen = 1;
      end
      k++;
      if (m_ack) got = 1;
    end
    lat = got ? k : -1;
    ack_t = cyc_n;
    if (!keep) begin cyc = 1'b0; stb = 1'b0; end
  endtask

  task automatic do_op(input logic w, input logic [31:0] a, d,
                       input logic [3:0] s, input logic keep);
    int wt, idx;
    wt  = dsel ? 2 : 0;
    idx = int'(a[21:2]);
    xfer(w, a, d, s, keep);
    chk("lat", 32'(lat), 32'(w ? 4 + wt : 2 + wt));
    chk("we_low", 32'(wl), 32'(w ? 1 + wt : 0));
    chk("oe_low", 32'(ol), 32'(w ? 0 : 1 + wt));
    chk("addr", {12'b0, sa}, {12'b0, a[21:2]});
    chk("be_n", {28'b0, sb}, {28'b0, ~s});
    if (w) ref_wr(idx, d, s);
    else chk("rdata", m_rdat, ref_rd(idx));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int t1, k;
    reset = 1'b0; cyc = 0; stb = 0; we = 0; dsel = 0;
    adr = 0; dat = 0; sel = 0; pl_go = 0; pl_a = 0; pl_d = 0;
    repeat (3) @(negedge clk);
    chk("rst_pins0", {23'b0, ack0, ce0, oe0, we0, doe0, be0},
        {23'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF});
    chk("rst_pins2", {23'b0, ack2, ce2, oe2, we2, doe2, be2},
        {23'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF});
    chk("rst_rd0", rd0, 32'd0);
    chk("rst_do0", do0, 32'd0);
    chk("rst_a0", {12'b0, a0}, 32'd0);
    @(negedge clk) reset = 1'b1;

    preload(20'h01000, 32'hDEAD_BEEF);
    preload(20'h00002, 32'h1122_3344);

    do_op(1'b0, 32'h8000_4000, 32'd0, 4'hF, 1'b0);
    chk("t1_data", m_rdat, 32'hDEAD_BEEF);

    do_op(1'b1, 32'h8000_0008, 32'h0000_00AB, 4'h1, 1'b0);
    do_op(1'b0, 32'h8000_0008, 32'd0, 4'hF, 1'b0);
    chk("t2_word", m_rdat, 32'h1122_33AB);

    dsel = 1'b1;
    do_op(1'b1, 32'h0000_0100, 32'h0BAD_F00D, 4'hF, 1'b0);
    do_op(1'b0, 32'h0000_0100, 32'd0, 4'hF, 1'b0);
    chk("t3_data", m_rdat, 32'h0BAD_F00D);

    dsel = 1'b0;
    @(negedge clk);
    cyc = 1; stb = 1; we = 1;
    adr = 32'h0000_0100; dat = 32'hCAFE_F00D; sel = 4'hF;
    k = 0;
    while (m_we_n && k < 10) begin @(negedge clk); k++; end
    chk("t4_pulse", {31'b0, m_we_n}, 32'd0);
    #2 reset = 1'b0;
    #1 chk("t4_rst", {29'b0, m_we_n, m_ce_n, m_doe}, 32'd6);
    stb = 1'b0;
    @(negedge clk) reset = 1'b1;
    n = 0;
    repeat (6) begin @(negedge clk); if (m_ack) n++; end
    chk("t4_no_ack", 32'(n), 32'd0);
    cyc = 1'b0;
    do_op(1'b0, 32'h8000_4000, 32'd0, 4'hF, 1'b0);
    chk("t4_read", m_rdat, 32'hDEAD_BEEF);

    do_op(1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF, 1'b1);
    t1 = ack_t;
    do_op(1'b0, 32'h0000_0200, 32'd0, 4'hF, 1'b0);
    chk("t5_gap", 32'(ack_t - t1), 32'd3);
    chk("t5_data", m_rdat, 32'h1234_5678);

    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h0000_0040; sel = 4'hF;
    @(negedge clk);
    chk("t6_in_read", {31'b0, m_oe_n}, 32'd0);
    cyc = 0; stb = 0;
    n = 0;
    repeat (2) begin @(negedge clk); if (m_ack) n++; end
    chk("t6_ce_idle", {31'b0, m_ce_n}, 32'd1);
    chk("t6_no_ack", 32'(n), 32'd0);
    do_op(1'b0, 32'h0000_0040, 32'd0, 4'hF, 1'b0);

    dsel = 1'b1;
    @(negedge clk);
    cyc = 1; stb = 1; we = 1;
    adr = 32'h0000_0080; dat = 32'h5555_AAAA; sel = 4'hF;
    @(negedge clk);
    cyc = 0; stb = 0;
    n = 0; k = 0;
    while (!m_ce_n && k < 20) begin
      if (!m_we_n) n++;
      @(negedge clk); k++;
    end
    chk("abort_we", 32'(n), 32'd3);
    ref_wr(32, 32'h5555_AAAA, 4'hF);
    do_op(1'b0, 32'h0000_0080, 32'd0, 4'hF, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra;
      logic [19:0] ix;
      dsel = 1'($urandom_range(0, 1));
      ix = ($urandom_range(0, 1) == 1)
         ? 20'($urandom_range(0, 7))
         : 20'hFFFF8 + 20'($urandom_range(0, 7));
      ra = ($urandom() & 32'hFFC0_0003) | {10'b0, ix, 2'b0};
      do_op(1'($urandom_range(0, 1)), ra, $urandom(),
            4'($urandom_range(0, 15)), 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
